// File: rtl/bsm_recursion_unit.sv
// rtl/bsm_recursion_unit.sv - 8-state backward state-metric (beta) recursion unit
//
// Ports:
//   clock, reset_n        single clock, synchronous active-low reset
//   start, len            block start pulse and number of trellis steps
//   init_mode             0: all betas 0, 1: terminated (beta[0]=0, others -2^(W-2))
//   mode_maxstar          0: max-log ACS, 1: max* ACS with small correction
//   norm_en               subtract new state-0 metric from every state each step
//   gamma_in/valid/ready  branch metrics g[k][b] at (2k+b)*W, one trellis step per transfer
//   beta_out/valid/ready  resulting beta vector, state k at k*W
//   beta_last             marks the final step of a block
//   busy, done            block in progress / one-cycle pulse after final beta transfer
module bsm_recursion_unit #(
    parameter int W     = 12,
    parameter int LEN_W = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              init_mode,
    input  logic              mode_maxstar,
    input  logic              norm_en,
    input  logic [16*W-1:0]   gamma_in,
    input  logic              gamma_valid,
    output logic              gamma_ready,
    output logic [8*W-1:0]    beta_out,
    output logic              beta_valid,
    input  logic              beta_ready,
    output logic              beta_last,
    output logic              busy,
    output logic              done
);

    // Internal arithmetic width: W+1 for the sums, +1 for the correction and
    // normalisation, +1 guard bit so extreme metric spreads cannot wrap.
    localparam int SW = W + 3;

    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (W-1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 <<< (W-1)));
    localparam logic signed [W-1:0]  TERM    = W'(-(1 <<< (W-2)));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [LEN_W-1:0]       cnt;
    logic                   maxstar_q;
    logic                   norm_q;
    logic signed [W-1:0]    beta_q   [8];
    logic signed [W-1:0]    beta_nxt [8];
    logic signed [SW-1:0]   r        [8];
    logic                   gamma_fire;
    logic                   beta_fire;

    assign gamma_ready = (state == RUN) && (!beta_valid || beta_ready);
    assign gamma_fire  = gamma_valid && gamma_ready;
    assign beta_fire   = beta_valid && beta_ready;
    assign busy        = (state != IDLE);

    // Add-compare-select for all eight states. New states 2m and 2m+1 share
    // predecessors beta[m] (branch 0) and beta[m+4] (branch 1).
    always_comb begin
        logic signed [W-1:0]  g0;
        logic signed [W-1:0]  g1;
        logic signed [W-1:0]  b0;
        logic signed [W-1:0]  b1;
        logic signed [SW-1:0] s0;
        logic signed [SW-1:0] s1;
        logic signed [SW-1:0] diff;
        logic        [SW-1:0] ad;
        logic signed [SW-1:0] corr;
        logic signed [SW-1:0] nr;
        g0   = '0;
        g1   = '0;
        b0   = '0;
        b1   = '0;
        s0   = '0;
        s1   = '0;
        diff = '0;
        ad   = '0;
        corr = '0;
        nr   = '0;
        for (int k = 0; k < 8; k++) begin
            g0   = gamma_in[(2*k)*W +: W];
            g1   = gamma_in[(2*k+1)*W +: W];
            b0   = beta_q[k/2];
            b1   = beta_q[k/2 + 4];
            s0   = {{3{g0[W-1]}}, g0} + {{3{b0[W-1]}}, b0};
            s1   = {{3{g1[W-1]}}, g1} + {{3{b1[W-1]}}, b1};
            diff = s0 - s1;
            ad   = diff[SW-1] ? -diff : diff;
            corr = '0;
            if (maxstar_q) begin
                if (ad <= SW'(1))
                    corr = SW'(2);
                else if (ad <= SW'(3))
                    corr = SW'(1);
            end
            r[k] = ((s0 >= s1) ? s0 : s1) + corr;
        end
        // Normalise against the new state-0 metric, then saturate to W bits.
        for (int k = 0; k < 8; k++) begin
            nr = norm_q ? (r[k] - r[0]) : r[k];
            if (nr > SAT_MAX)
                beta_nxt[k] = SAT_MAX[W-1:0];
            else if (nr < SAT_MIN)
                beta_nxt[k] = SAT_MIN[W-1:0];
            else
                beta_nxt[k] = nr[W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            maxstar_q  <= 1'b0;
            norm_q     <= 1'b0;
            beta_out   <= '0;
            beta_valid <= 1'b0;
            beta_last  <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < 8; k++)
                beta_q[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        state     <= RUN;
                        cnt       <= len;
                        maxstar_q <= mode_maxstar;
                        norm_q    <= norm_en;
                        for (int k = 0; k < 8; k++)
                            beta_q[k] <= (init_mode && (k != 0)) ? TERM : '0;
                    end
                end
                RUN, DRAIN: begin
                    if (gamma_fire) begin
                        // Covers the simultaneous beta transfer case: valid stays high
                        // and the new vector replaces the one just consumed.
                        for (int k = 0; k < 8; k++) begin
                            beta_q[k]          <= beta_nxt[k];
                            beta_out[k*W +: W] <= beta_nxt[k];
                        end
                        beta_valid <= 1'b1;
                        beta_last  <= (cnt == LEN_W'(1));
                        cnt        <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1))
                            state <= DRAIN;
                    end else if (beta_fire) begin
                        beta_valid <= 1'b0;
                        beta_last  <= 1'b0;
                        if (state == DRAIN) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsm_recursion_unit.sv
// tb/tb_bsm_recursion_unit.sv - directed self-checking bench for bsm_recursion_unit
module tb_bsm_recursion_unit;

    localparam int W     = 12;
    localparam int LEN_W = 10;

    logic              clock;
    logic              reset_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              init_mode;
    logic              mode_maxstar;
    logic              norm_en;
    logic [16*W-1:0]   gamma_in;
    logic              gamma_valid;
    logic              gamma_ready;
    logic [8*W-1:0]    beta_out;
    logic              beta_valid;
    logic              beta_ready;
    logic              beta_last;
    logic              busy;
    logic              done;

    int vectors;
    int miscompares;

    logic [16*W-1:0]   gtmp;
    logic [8*W-1:0]    etmp;

    bsm_recursion_unit #(.W(W), .LEN_W(LEN_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .len          (len),
        .init_mode    (init_mode),
        .mode_maxstar (mode_maxstar),
        .norm_en      (norm_en),
        .gamma_in     (gamma_in),
        .gamma_valid  (gamma_valid),
        .gamma_ready  (gamma_ready),
        .beta_out     (beta_out),
        .beta_valid   (beta_valid),
        .beta_ready   (beta_ready),
        .beta_last    (beta_last),
        .busy         (busy),
        .done         (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [16*W-1:0] gpair(input int a, input int b);
        logic [16*W-1:0] g;
        for (int k = 0; k < 8; k++) begin
            g[(2*k)*W +: W]   = W'(a);
            g[(2*k+1)*W +: W] = W'(b);
        end
        return g;
    endfunction

    function automatic logic [8*W-1:0] rep8(input int v);
        logic [8*W-1:0] e;
        for (int k = 0; k < 8; k++)
            e[k*W +: W] = W'(v);
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic begin_block(input int n, input logic im, input logic ms, input logic ne);
        start        = 1'b1;
        len          = LEN_W'(n);
        init_mode    = im;
        mode_maxstar = ms;
        norm_en      = ne;
        tick();
        start        = 1'b0;
    endtask

    // Single-step block: start, accept one gamma; returns with the beta visible.
    task automatic single(input logic ms, input logic ne, input logic [16*W-1:0] g);
        begin_block(1, 1'b0, ms, ne);
        gamma_in    = g;
        gamma_valid = 1'b1;
        tick();
        gamma_valid = 1'b0;
    endtask

    // Final beta is visible with beta_ready=1; next edge transfers it.
    task automatic end_block(input string tag);
        tick();
        chk1({tag, "_done"}, done, 1'b1);
        chk1({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        len          = '0;
        init_mode    = 1'b0;
        mode_maxstar = 1'b0;
        norm_en      = 1'b0;
        gamma_in     = '0;
        gamma_valid  = 1'b0;
        beta_ready   = 1'b1;
        tick();
        tick();
        chkv("rst_beta_out", beta_out, '0);
        chk1("rst_beta_valid", beta_valid, 1'b0);
        chk1("rst_beta_last", beta_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_gamma_ready", gamma_ready, 1'b0);
        reset_n = 1'b1;
        tick();

        // start with len=0 is ignored
        start = 1'b1;
        len   = '0;
        tick();
        start = 1'b0;
        chk1("len0_busy", busy, 1'b0);

        // basic: len=1, all g=5
        begin_block(1, 1'b0, 1'b0, 1'b0);
        chk1("basic_busy", busy, 1'b1);
        chk1("basic_gready", gamma_ready, 1'b1);
        gamma_in    = gpair(5, 5);
        gamma_valid = 1'b1;
        tick();
        gamma_valid = 1'b0;
        chk1("basic_valid", beta_valid, 1'b1);
        chk1("basic_last", beta_last, 1'b1);
        chkv("basic_beta", beta_out, rep8(5));
        chk1("basic_drain_gready", gamma_ready, 1'b0);
        end_block("basic");
        chk1("basic_valid_clr", beta_valid, 1'b0);
        tick();
        chk1("basic_done_pulse", done, 1'b0);

        // terminated init, all g=0: states 0,1 -> 0, 2..7 -> -1024
        begin_block(1, 1'b1, 1'b0, 1'b0);
        gamma_in    = gpair(0, 0);
        gamma_valid = 1'b1;
        tick();
        gamma_valid = 1'b0;
        etmp = rep8(-1024);
        etmp[0 +: W] = '0;
        etmp[W +: W] = '0;
        chkv("term_beta", beta_out, etmp);
        end_block("term");

        // trellis connectivity: step 2 g[k][0]=k, g[k][1]=100 after terminated step 1
        begin_block(2, 1'b1, 1'b0, 1'b0);
        gamma_in    = gpair(0, 0);
        gamma_valid = 1'b1;
        tick();
        chkv("trel_step1", beta_out, etmp);
        chk1("trel_last1", beta_last, 1'b0);
        for (int k = 0; k < 8; k++) begin
            gtmp[(2*k)*W +: W]   = W'(k);
            gtmp[(2*k+1)*W +: W] = W'(100);
        end
        gamma_in = gtmp;
        tick();
        gamma_valid = 1'b0;
        etmp = rep8(-924);
        for (int k = 0; k < 4; k++)
            etmp[k*W +: W] = W'(k);
        chkv("trel_step2", beta_out, etmp);
        chk1("trel_last2", beta_last, 1'b1);
        end_block("trel");

        // saturation, len=3, plus a start pulse while busy that must be ignored
        begin_block(3, 1'b0, 1'b0, 1'b0);
        gamma_in    = gpair(2047, 2047);
        gamma_valid = 1'b1;
        start       = 1'b1;
        len         = LEN_W'(1);
        init_mode   = 1'b1;
        tick();
        start = 1'b0;
        chkv("sat_step1", beta_out, rep8(2047));
        chk1("sat_last1", beta_last, 1'b0);
        tick();
        chkv("sat_step2", beta_out, rep8(2047));
        chk1("sat_last2", beta_last, 1'b0);
        tick();
        gamma_valid = 1'b0;
        chkv("sat_step3", beta_out, rep8(2047));
        chk1("sat_last3", beta_last, 1'b1);
        end_block("sat");

        // backpressure: beta_ready low 3 cycles after step 1
        begin_block(3, 1'b0, 1'b0, 1'b0);
        gamma_in    = gpair(1, 1);
        gamma_valid = 1'b1;
        tick();
        chkv("bp_step1", beta_out, rep8(1));
        beta_ready = 1'b0;
        gamma_in   = gpair(2, 2);
        #1;
        chk1("bp_gready_low", gamma_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chkv("bp_hold_beta", beta_out, rep8(1));
            chk1("bp_hold_valid", beta_valid, 1'b1);
            chk1("bp_hold_gready", gamma_ready, 1'b0);
        end
        beta_ready = 1'b1;
        tick();
        chkv("bp_step2", beta_out, rep8(3));
        chk1("bp_valid2", beta_valid, 1'b1);
        chk1("bp_last2", beta_last, 1'b0);
        gamma_in = gpair(4, 4);
        tick();
        gamma_valid = 1'b0;
        chkv("bp_step3", beta_out, rep8(7));
        chk1("bp_last3", beta_last, 1'b1);
        end_block("bp");

        // max* correction
        single(1'b1, 1'b0, gpair(10, 10));
        chkv("ms_eq", beta_out, rep8(12));
        end_block("ms_eq");
        single(1'b1, 1'b0, gpair(13, 10));
        chkv("ms_d3", beta_out, rep8(14));
        end_block("ms_d3");
        single(1'b1, 1'b0, gpair(20, 10));
        chkv("ms_d10", beta_out, rep8(20));
        end_block("ms_d10");
        single(1'b1, 1'b0, gpair(10, 12));
        chkv("ms_d2", beta_out, rep8(13));
        end_block("ms_d2");
        single(1'b1, 1'b0, gpair(10, 14));
        chkv("ms_d4", beta_out, rep8(14));
        end_block("ms_d4");
        single(1'b0, 1'b0, gpair(10, 10));
        chkv("maxlog_eq", beta_out, rep8(10));
        end_block("maxlog_eq");

        // normalisation: g[k][0]=10+k, g[k][1]=0 -> state k holds k
        for (int k = 0; k < 8; k++) begin
            gtmp[(2*k)*W +: W]   = W'(10 + k);
            gtmp[(2*k+1)*W +: W] = '0;
        end
        single(1'b0, 1'b1, gtmp);
        for (int k = 0; k < 8; k++)
            etmp[k*W +: W] = W'(k);
        chkv("norm_ramp", beta_out, etmp);
        end_block("norm_ramp");
        single(1'b1, 1'b1, gpair(13, 10));
        chkv("norm_ms", beta_out, rep8(0));
        end_block("norm_ms");

        // reset mid-block
        begin_block(5, 1'b0, 1'b0, 1'b0);
        gamma_in    = gpair(5, 5);
        gamma_valid = 1'b1;
        tick();
        gamma_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        chkv("mrst_beta_out", beta_out, '0);
        chk1("mrst_valid", beta_valid, 1'b0);
        chk1("mrst_last", beta_last, 1'b0);
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_gready", gamma_ready, 1'b0);
        reset_n = 1'b1;
        tick();
        chk1("mrst_no_done", done, 1'b0);
        single(1'b0, 1'b0, gpair(7, 7));
        chkv("mrst_restart", beta_out, rep8(7));
        chk1("mrst_restart_last", beta_last, 1'b1);
        end_block("mrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
